// File: rtl/butterfly_r2_shared_pkg.sv
// rtl/butterfly_r2_shared_pkg.sv - fft_pkg types and reduction helpers for the shared radix-2 butterfly (BUTTERFLY_SAT_EN selects saturation)
package fft_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int FACTOR_WIDTH = 16;
    localparam int FRAC_BITS    = 14;
    localparam int ROUND_CONST  = 1 << (FRAC_BITS - 1);
    localparam int PROD_W       = DATA_WIDTH + FACTOR_WIDTH;
    // Two guard bits: one for the product sum, one so the rounding add never wraps.
    localparam int WIDE_W       = PROD_W + 2;

    typedef logic signed [WIDE_W-1:0]       wide_t;
    typedef logic signed [PROD_W-1:0]       prod_t;
    typedef logic signed [DATA_WIDTH-1:0]   data_t;
    typedef logic signed [FACTOR_WIDTH-1:0] factor_t;

    typedef struct packed {
        data_t re;
        data_t im;
    } cplx_t;

    typedef struct packed {
        factor_t re;
        factor_t im;
    } twiddle_t;

    typedef enum logic {
        BFLY_DIF = 1'b0,
        BFLY_DIT = 1'b1
    } bfly_mode_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_0,
        PH_1
    } phase_e;

    localparam wide_t SAT_MAX = wide_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam wide_t SAT_MIN = ~SAT_MAX;

    function automatic wide_t ext(input data_t v);
        return wide_t'(v);
    endfunction

    function automatic wide_t half_if(input wide_t v, input logic sc);
        return sc ? ((v + wide_t'(1)) >>> 1) : v;
    endfunction

    function automatic data_t sat_or_wrap(input wide_t v);
`ifdef BUTTERFLY_SAT_EN
        if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
`endif
        return v[DATA_WIDTH-1:0];
    endfunction

    function automatic logic is_clipped(input wide_t v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

endpackage

// File: rtl/butterfly_r2_shared_if.sv
// rtl/butterfly_r2_shared_if.sv - handshake/data bundle of the shared butterfly (sat_flag present with BUTTERFLY_SAT_EN)
interface butterfly_r2_shared_if;
    import fft_pkg::*;

    logic     in_valid;
    logic     in_ready;
    logic     mode;
    logic     scale;
    cplx_t    in_x0;
    cplx_t    in_x1;
    twiddle_t w;
    logic     out_valid;
    cplx_t    out_x0;
    cplx_t    out_x1;
`ifdef BUTTERFLY_SAT_EN
    logic     sat_flag;

    modport master (output in_valid, mode, scale, in_x0, in_x1, w,
                    input  in_ready, out_valid, out_x0, out_x1, sat_flag);
    modport slave  (input  in_valid, mode, scale, in_x0, in_x1, w,
                    output in_ready, out_valid, out_x0, out_x1, sat_flag);
`else
    modport master (output in_valid, mode, scale, in_x0, in_x1, w,
                    input  in_ready, out_valid, out_x0, out_x1);
    modport slave  (input  in_valid, mode, scale, in_x0, in_x1, w,
                    output in_ready, out_valid, out_x0, out_x1);
`endif

endinterface

// File: rtl/butterfly_r2_shared_cmul.sv
// rtl/butterfly_r2_shared_cmul.sv - cmul_shared: two-multiplier, two-phase complex multiply with half-up rounding
module cmul_shared
    import fft_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     phase,
    input  cplx_t    p,
    input  twiddle_t w,
    output wide_t    res_re,
    output wide_t    res_im,
    output logic     res_valid
);

    factor_t op_b0;
    factor_t op_b1;
    prod_t   m0;
    prod_t   m1;
    prod_t   rr;
    prod_t   ii;
    prod_t   ri;
    prod_t   ir;
    logic    fin;

    // Phase 0 feeds (wr, wi), phase 1 swaps to (wi, wr); the p operands never move.
    assign op_b0 = phase ? w.im : w.re;
    assign op_b1 = phase ? w.re : w.im;
    assign m0    = prod_t'(p.re) * prod_t'(op_b0);
    assign m1    = prod_t'(p.im) * prod_t'(op_b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            fin       <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            fin       <= en & phase;
            res_valid <= fin;
        end
    end

    always_ff @(posedge clk) begin
        if (en && !phase) begin
            rr <= m0;
            ii <= m1;
        end
        if (en && phase) begin
            ri <= m0;
            ir <= m1;
        end
        if (fin) begin
            res_re <= (wide_t'(rr) - wide_t'(ii) + wide_t'(ROUND_CONST)) >>> FRAC_BITS;
            res_im <= (wide_t'(ri) + wide_t'(ir) + wide_t'(ROUND_CONST)) >>> FRAC_BITS;
        end
    end

endmodule

// File: rtl/butterfly_r2_shared.sv
// rtl/butterfly_r2_shared.sv - radix-2 DIF/DIT butterfly, one result per 2 clocks on a shared cmul (BUTTERFLY_SAT_EN: saturate + sat_flag)
module butterfly_r2_shared
    import fft_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    butterfly_r2_shared_if.slave bus
);

    phase_e     state;
    logic       fire;

    cplx_t      s_a;
    cplx_t      s_b;
    cplx_t      s_p;
    twiddle_t   s_w;
    bfly_mode_e s_mode;
    logic       s_scale;

    cplx_t      q_a;
    cplx_t      q_b;
    bfly_mode_e q_mode;
    logic       q_scale;

    wide_t      pre_re_w;
    wide_t      pre_im_w;
    wide_t      res_re;
    wide_t      res_im;
    logic       res_valid;
    data_t      m_re;
    data_t      m_im;
    wide_t      x0r_w;
    wide_t      x0i_w;
    wide_t      x1r_w;
    wide_t      x1i_w;

    assign fire = bus.in_valid && bus.in_ready;

    // DIF multiplies (a-b): form, scale and reduce it on the way into the slot.
    assign pre_re_w = half_if(ext(bus.in_x0.re) - ext(bus.in_x1.re), bus.scale);
    assign pre_im_w = half_if(ext(bus.in_x0.im) - ext(bus.in_x1.im), bus.scale);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PH_IDLE;
            bus.in_ready <= 1'b1;
        end else begin
            bus.in_ready <= !fire;
            case (state)
                PH_IDLE: if (fire) state <= PH_0;
                PH_0:    state <= PH_1;
                PH_1:    state <= fire ? PH_0 : PH_IDLE;
                default: state <= PH_IDLE;
            endcase
        end
    end

    // q_* carries a slot past PH1 so the next slot can reuse s_* while the sums are formed.
    always_ff @(posedge clk) begin
        if (fire) begin
            s_a     <= bus.in_x0;
            s_b     <= bus.in_x1;
            s_w     <= bus.w;
            s_mode  <= bfly_mode_e'(bus.mode);
            s_scale <= bus.scale;
            if (bfly_mode_e'(bus.mode) == BFLY_DIT) s_p <= bus.in_x1;
            else                                    s_p <= {sat_or_wrap(pre_re_w), sat_or_wrap(pre_im_w)};
        end
        if (state == PH_1) begin
            q_a     <= s_a;
            q_b     <= s_b;
            q_mode  <= s_mode;
            q_scale <= s_scale;
        end
    end

    cmul_shared u_cmul (
        .clk       (clk),
        .rst       (rst),
        .en        (state != PH_IDLE),
        .phase     (state == PH_1),
        .p         (s_p),
        .w         (s_w),
        .res_re    (res_re),
        .res_im    (res_im),
        .res_valid (res_valid)
    );

    always_comb begin
        m_re = sat_or_wrap(res_re);
        m_im = sat_or_wrap(res_im);
        if (q_mode == BFLY_DIT) begin
            x0r_w = half_if(ext(q_a.re) + ext(m_re), q_scale);
            x0i_w = half_if(ext(q_a.im) + ext(m_im), q_scale);
            x1r_w = half_if(ext(q_a.re) - ext(m_re), q_scale);
            x1i_w = half_if(ext(q_a.im) - ext(m_im), q_scale);
        end else begin
            x0r_w = half_if(ext(q_a.re) + ext(q_b.re), q_scale);
            x0i_w = half_if(ext(q_a.im) + ext(q_b.im), q_scale);
            x1r_w = res_re;
            x1i_w = res_im;
        end
    end

`ifdef BUTTERFLY_SAT_EN
    logic s_clip;
    logic q_clip;
    logic clip_any;

    always_ff @(posedge clk) begin
        if (fire) s_clip <= (bfly_mode_e'(bus.mode) == BFLY_DIF) &&
                            (is_clipped(pre_re_w) || is_clipped(pre_im_w));
        if (state == PH_1) q_clip <= s_clip;
    end

    assign clip_any = q_clip | is_clipped(res_re) | is_clipped(res_im) |
                      is_clipped(x0r_w) | is_clipped(x0i_w) | is_clipped(x1r_w) | is_clipped(x1i_w);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_x0    <= '0;
            bus.out_x1    <= '0;
`ifdef BUTTERFLY_SAT_EN
            bus.sat_flag  <= 1'b0;
`endif
        end else begin
            bus.out_valid <= res_valid;
            if (res_valid) begin
                bus.out_x0   <= {sat_or_wrap(x0r_w), sat_or_wrap(x0i_w)};
                bus.out_x1   <= {sat_or_wrap(x1r_w), sat_or_wrap(x1i_w)};
`ifdef BUTTERFLY_SAT_EN
                bus.sat_flag <= clip_any;
`endif
            end
        end
    end

endmodule
